// File: rtl/mul_share_sched_pkg.sv
// Shared types and helpers for the multiplier-sharing scheduler: FSM encoding,
// default sizes and the round-robin grant picker.
package mul_share_sched_pkg;

    localparam int DEF_W     = 3;
    localparam int DEF_N_REQ = 4;
    localparam int MAX_REQ   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic               any;
        logic [2:0]         idx;
        logic [MAX_REQ-1:0] gnt;
    } pick_t;

    // First set bit of req scanning upward from ptr, wrapping at n (n <= MAX_REQ).
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [2:0]         ptr,
                                      input logic [3:0]         n);
        pick_t      p;
        logic [3:0] j;
        p = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = {1'b0, ptr} + 4'(k);
            if (j >= n) j = j - n;
            if (!p.any && (4'(k) < n) && req[j[2:0]]) begin
                p.any         = 1'b1;
                p.idx         = j[2:0];
                p.gnt[j[2:0]] = 1'b1;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mul_share_sched_if.sv
// Request/response bundle between clients (master) and the scheduler (slave).
interface mul_share_sched_if
    import mul_share_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W,
    parameter int IDW   = 2
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never waits on ready, and a held response keeps its payload
    // stable until that transfer.
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic [N_REQ-1:0]   req_ready;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [2*W-1:0]     rsp_prod;
    logic               rsp_hi;
    logic               rsp_ready;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_prod, rsp_hi
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_prod, rsp_hi
    );

endinterface

// File: rtl/mul_share_sched_mul_unit.sv
// Shared combinational WxW unsigned multiplier with a product-overflows-W flag.
module mul_unit
    import mul_share_sched_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] prod,
    output logic           hi
);

    assign prod = (2*W)'(a) * (2*W)'(b);
    assign hi   = |prod[2*W-1:W];

endmodule

// File: rtl/mul_share_sched.sv
// Round-robin scheduler that serialises requesters onto one shared multiplier:
// IDLE grants and latches operands, CALC multiplies, HOLD waits for the consumer.
module mul_share_sched
    import mul_share_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W,
    parameter int IDW   = 2
) (
    input  logic                clk,
    input  logic                reset,
    mul_share_sched_if.slave    bus,
    output state_t              dbg_state
);

    state_t             state, state_nxt;
    logic [W-1:0]       op_a, op_b;
    logic [IDW-1:0]     cur_id, rr_ptr, win_id;
    logic [MAX_REQ-1:0] req_pad;
    pick_t              pick;
    logic               pick_unused;
    logic [N_REQ-1:0]   req_ready_c;
    logic               accept, compute, release_rsp;
    logic [2*W-1:0]     mul_prod;
    logic               mul_hi;
    logic [2*W-1:0]     rsp_prod_q;
    logic               rsp_hi_q, rsp_valid_q;
    logic [IDW-1:0]     rsp_id_q;

    always_comb begin
        req_pad              = '0;
        req_pad[N_REQ-1:0]   = bus.req_valid;
    end

    assign pick        = rr_pick(req_pad, 3'(rr_ptr), 4'(N_REQ));
    assign win_id      = IDW'(pick.idx);
    assign pick_unused = ^pick;

    mul_unit #(.W(W)) u_mul (
        .a    (op_a),
        .b    (op_b),
        .prod (mul_prod),
        .hi   (mul_hi)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        req_ready_c = '0;
        accept      = 1'b0;
        compute     = 1'b0;
        release_rsp = 1'b0;
        case (state)
            IDLE: begin
                req_ready_c = pick.gnt[N_REQ-1:0];
                if (pick.any) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                compute   = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (bus.rsp_ready) begin
                    release_rsp = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are copied at grant so later changes on the request lines are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a        <= '0;
            op_b        <= '0;
            cur_id      <= '0;
            rr_ptr      <= '0;
            rsp_prod_q  <= '0;
            rsp_hi_q    <= 1'b0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                op_a   <= bus.req_a[int'(win_id)*W +: W];
                op_b   <= bus.req_b[int'(win_id)*W +: W];
                cur_id <= win_id;
                rr_ptr <= (win_id == IDW'(N_REQ-1)) ? '0 : win_id + IDW'(1);
            end
            if (compute) begin
                rsp_prod_q  <= mul_prod;
                rsp_hi_q    <= mul_hi;
                rsp_id_q    <= cur_id;
                rsp_valid_q <= 1'b1;
            end
            if (release_rsp) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_prod  = rsp_prod_q;
    assign bus.rsp_hi    = rsp_hi_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed bench for mul_share_sched: reset, single requests, round-robin order,
// backpressure, operand isolation after grant and reset during CALC.
module tb_mul_share_sched;
    import mul_share_sched_pkg::*;

    localparam int N   = 4;
    localparam int W   = 3;
    localparam int IDW = 2;

    logic   clk = 1'b0;
    logic   reset;
    state_t dbg_state;
    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    int     last_cyc;

    logic [W-1:0]   ta [N] = '{3'd1, 3'd3, 3'd5, 3'd2};
    logic [W-1:0]   tb [N] = '{3'd2, 3'd4, 3'd6, 3'd3};
    logic [2*W-1:0] tp [N] = '{6'd2, 6'd12, 6'd30, 6'd6};
    logic           th [N] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0]     exp_q[$];
    logic [1:0]     e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_share_sched_if #(.N_REQ(N), .W(W), .IDW(IDW)) bus ();

    mul_share_sched #(.N_REQ(N), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    task automatic check_rsp(input string tag, input logic [1:0] id,
                             input logic [5:0] p, input logic h);
        chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_id"},    32'(bus.rsp_id),    32'(id));
        chk({tag, "_prod"},  32'(bus.rsp_prod),  32'(p));
        chk({tag, "_hi"},    32'(bus.rsp_hi),    32'(h));
    endtask

    task automatic run_single(input int i, input logic [2:0] a, input logic [2:0] b,
                              input logic [5:0] p, input logic h);
        @(negedge clk);
        bus.req_valid = 4'(1 << i);
        set_op(i, a, b);
        bus.rsp_ready = 1'b1;
        #1;
        chk($sformatf("single%0d_ready", i), 32'(bus.req_ready), 32'(1 << i));
        @(negedge clk);
        bus.req_valid = '0;
        chk($sformatf("single%0d_calc", i), 32'(dbg_state), 32'(CALC));
        chk($sformatf("single%0d_calc_valid", i), 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check_rsp($sformatf("single%0d", i), 2'(i), p, h);
        @(negedge clk);
        chk($sformatf("single%0d_drop", i), 32'(bus.rsp_valid), 32'd0);
        chk($sformatf("single%0d_idle", i), 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 32'(dbg_state),     32'(IDLE));
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_id",    32'(bus.rsp_id),    32'd0);
        chk("rst_prod",  32'(bus.rsp_prod),  32'd0);
        chk("rst_hi",    32'(bus.rsp_hi),    32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;

        // zero operand, max product, small product; leaves rr_ptr back at 0
        run_single(0, 3'd7, 3'd0, 6'd0,  1'b0);
        run_single(2, 3'd7, 3'd7, 6'd49, 1'b1);
        run_single(3, 3'd3, 3'd2, 6'd6,  1'b0);

        // all requesters valid: grants 0,1,2,3,0 three cycles apart
        @(negedge clk);
        for (int i = 0; i < N; i++) set_op(i, ta[i], tb[i]);
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        last_cyc = 0;
        for (int t = 0; t < 5; t++) begin
            e = exp_q.pop_front();
            #1;
            chk($sformatf("rr%0d_ready", t), 32'(bus.req_ready), 32'(1 << e));
            @(negedge clk);
            @(negedge clk);
            check_rsp($sformatf("rr%0d", t), e, tp[e], th[e]);
            if (t > 0) chk($sformatf("rr%0d_spacing", t), 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
            @(negedge clk);
            chk($sformatf("rr%0d_drop", t), 32'(bus.rsp_valid), 32'd0);
        end

        // backpressure on requester 1's response
        bus.rsp_ready = 1'b0;
        #1;
        chk("bp_grant", 32'(bus.req_ready), 32'b0010);
        @(negedge clk);
        @(negedge clk);
        check_rsp("bp_first", 2'd1, 6'd12, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", k), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("bp%0d_prod", k),  32'(bus.rsp_prod),  32'd12);
            chk($sformatf("bp%0d_id", k),    32'(bus.rsp_id),    32'd1);
            chk($sformatf("bp%0d_ready", k), 32'(bus.req_ready), 32'd0);
            chk($sformatf("bp%0d_state", k), 32'(dbg_state),     32'(HOLD));
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_release_state", 32'(dbg_state),     32'(IDLE));
        chk("bp_next_grant",    32'(bus.req_ready), 32'b0100);
        bus.req_valid = '0;

        // operands changed after grant must not affect the product
        @(negedge clk);
        set_op(1, 3'd5, 3'd3);
        bus.req_valid = 4'b0010;
        #1;
        chk("opchg_ready", 32'(bus.req_ready), 32'b0010);
        @(negedge clk);
        set_op(1, 3'd1, 3'd3);
        bus.req_valid = '0;
        chk("opchg_calc", 32'(dbg_state), 32'(CALC));
        @(negedge clk);
        check_rsp("opchg", 2'd1, 6'd15, 1'b1);
        @(negedge clk);
        chk("opchg_idle", 32'(dbg_state), 32'(IDLE));

        // reset during CALC discards the transaction and restarts at requester 0
        for (int i = 0; i < N; i++) set_op(i, ta[i], tb[i]);
        bus.req_valid = 4'b1111;
        #1;
        chk("mrst_grant", 32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        chk("mrst_calc", 32'(dbg_state), 32'(CALC));
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mrst_state", 32'(dbg_state),     32'(IDLE));
        reset = 1'b0;
        #1;
        chk("mrst_ptr0", 32'(bus.req_ready), 32'b0001);
        @(negedge clk);
        chk("mrst_calc_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check_rsp("mrst_rsp", 2'd0, 6'd2, 1'b0);
        bus.req_valid = '0;
        @(negedge clk);
        chk("mrst_end", 32'(bus.rsp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_share_sched.md
Name: mul_share_sched

Overview:
- Sequencer and round-robin arbiter that shares one 3x3-bit unsigned multiplier among several requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The scheduler grants one requester at a time, latches its operands and drives the shared multiplier for one compute cycle.
- It returns a 6-bit product, a high-part flag and the requester ID on a valid/ready response channel.
- Sits between P1-level client logic and the combinational multiplier datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 3, operand width in bits; product width is 2*W.
- IDW, 2, requester ID width; must equal clog2(N_REQ).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_a  in  N_REQ*W  operand A for each requester; requester i occupies bits [i*W +: W].
- req_b  in  N_REQ*W  operand B, packed the same way.
- req_ready  out  N_REQ  one-hot accept strobe; a request is taken on a cycle where req_valid[i] and req_ready[i] are both 1.
- rsp_valid  out  1  response valid.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_prod  out  2*W  product a*b, unsigned.
- rsp_hi  out  1  1 when rsp_prod[2W-1:W] != 0, i.e. the product does not fit in W bits.
- rsp_ready  in  1  response consumer ready.

Behaviour:
- Reset (synchronous, reset=1 at clk edge):
  - state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_prod=0, rsp_hi=0.
  - Operand registers cleared; rr_ptr=0, so requester 0 has highest priority first.
- States: IDLE, CALC, HOLD.
- IDLE:
  - req_ready is combinational: one-hot on the winning requester, zero when no req_valid bit is set.
  - Winner = first set req_valid bit scanning from index rr_ptr upward, wrapping modulo N_REQ.
  - On an edge with any req_valid set: latch that winner's operands into op_a/op_b, latch its ID into cur_id, set rr_ptr=(winner+1) mod N_REQ, go to CALC.
  - No valid bits: stay in IDLE; rr_ptr unchanged.
- CALC:
  - req_ready=0.
  - The shared multiplier sees op_a/op_b.
  - At the edge: rsp_prod<=op_a*op_b at full 2W width (no truncation), rsp_hi<=|product[2W-1:W], rsp_id<=cur_id, rsp_valid<=1, go to HOLD.
- HOLD:
  - req_ready=0; rsp_valid=1 and all rsp_* fields stable until accepted.
  - rsp_ready=1 at the edge: rsp_valid<=0, go to IDLE.
  - rsp_ready=0: stay in HOLD (backpressure).
- Latency: request accepted at edge T, rsp_valid visible after edge T+1. Minimum 3 cycles per transaction when rsp_ready is held high.
- Requesters may drop req_valid before being granted; only the requester granted in IDLE is served.
- Operand values after acceptance are ignored: the latched copy is used.
- Fairness: a continuously requesting line waits at most N_REQ-1 other grants.
- A requester deasserting at the same edge it is granted: grant is decided on current-cycle req_valid, so a request present at the IDLE edge is served.
- Reset asserted in CALC or HOLD: the in-flight transaction is discarded, rsp_valid=0 next cycle, no response emitted.
- Boundaries:
  - a=7, b=7 gives prod=49 (6'b110001), hi=1.
  - Any operand 0 gives prod=0, hi=0.
  - rr_ptr wraps from N_REQ-1 to 0.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE=2'd0, CALC=2'd1, HOLD=2'd2);
  - the default W and N_REQ values;
  - the round-robin pick function (req vector, pointer) -> one-hot grant plus index.
- One natural sub-module: mul_unit. It is combinational, takes W-bit a and b, and outputs the 2W-bit prod and the hi flag. It is the shared datapath; the scheduler instantiates exactly one.

Test Plan:
- Reset, then a single request: reset=1 for 2 cycles, then req_valid=4'b0001, a0=3'b111, b0=3'b000, rsp_ready=1.
  - req_ready=0001 in cycle 0; rsp_valid=1 two edges later with id=0, prod=0, hi=0; back to IDLE next cycle.
- Maximum product: req 2 with a=7, b=7 -> rsp_id=2, rsp_prod=6'd49, rsp_hi=1. Also a=3, b=2 -> prod=6, hi=0.
- All requesters continuously valid with distinct operands, rsp_ready=1 -> grants in order 0,1,2,3,0, responses spaced exactly 3 cycles apart, each rsp_id matching its operands.
- Backpressure: rsp_ready=0 for 5 cycles during HOLD -> rsp_valid and rsp_prod held constant, req_ready stays 0. The next grant occurs only after the rsp_ready=1 edge.
- Operand change after grant: req 1 (a=5, b=3) accepted, then a1 changed to 1 -> rsp_prod=15, hi=1.
- Reset mid-operation: reset=1 during CALC -> no rsp_valid pulse; rr_ptr=0, so with all requesting the next grant goes to requester 0.
